// File: rtl/display_pkg.sv
// display_pkg
//   Shared types and constants for the display arbitration slice.
//   DISP_W           : width of one display word (4 hex digits).
//   disp_arb_state_t : arbiter FSM states (IDLE -> LOAD -> HOLD).
package display_pkg;

  localparam int unsigned DISP_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } disp_arb_state_t;

endpackage

// File: rtl/module_rr_arbiter.sv
// module_rr_arbiter
//   Combinational round-robin pick. Scans ptr+1, ptr+2, ... modulo N_REQ and
//   returns the first requester found.
//   req     : per-requester request, level
//   ptr     : index of the last winner
//   onehot  : one-hot winner (all zero when no request)
//   winner  : winner index (0 when no request)
//   any_req : at least one request is set
module module_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PTR_W-1:0] winner,
  output logic             any_req
);

  logic found;

  always_comb begin
    onehot  = '0;
    winner  = '0;
    found   = 1'b0;
    any_req = |req;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((32'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner      = idx;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/module_display_arbiter.sv
// module_display_arbiter
//   Time-shares the 7-segment display interface between N_REQ requesters.
//   The round-robin winner's word is written to the display register and kept
//   for at least HOLD_CYCLES before the display is granted again.
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active-low
//   req       : per-requester display request, level
//   req_data  : flattened words, slice i = [i*DATA_W +: DATA_W]
//   ack       : one-hot 1-cycle pulse when a requester's word is written
//   grant     : one-hot owner of the display during LOAD+HOLD
//   disp_data : word for the display register (data_in)
//   disp_we   : 1-cycle write strobe (we)
//   busy      : high while in LOAD or HOLD
module module_display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = DISP_W,
  parameter int unsigned HOLD_CYCLES = 10_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       disp_data,
  output logic                    disp_we,
  output logic                    busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);

  disp_arb_state_t   state;
  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  ptr;
  logic [N_REQ-1:0]  win_onehot;
  logic [PTR_W-1:0]  win_idx;
  logic              any_req;
  logic              take;
  logic [DATA_W-1:0] req_words [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_words[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  module_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req     (req),
    .ptr     (ptr),
    .onehot  (win_onehot),
    .winner  (win_idx),
    .any_req (any_req)
  );

  // Arbitration happens in IDLE and also on the last HOLD cycle, so with
  // continuous requests the next LOAD follows HOLD directly and each word is
  // on screen for exactly HOLD_CYCLES+1 cycles.
  assign take = any_req && ((state == IDLE) || ((state == HOLD) && (cnt == '0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= PTR_RST;
      ack       <= '0;
      grant     <= '0;
      disp_data <= '0;
      disp_we   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      disp_we <= 1'b0;
      ack     <= '0;
      case (state)
        IDLE: ;
        LOAD: begin
          cnt   <= CNT_LOAD;
          state <= HOLD;
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
      // A new grant overrides the IDLE/HOLD-exit updates above.
      if (take) begin
        state     <= LOAD;
        disp_data <= req_words[win_idx];
        grant     <= win_onehot;
        ack       <= win_onehot;
        disp_we   <= 1'b1;
        busy      <= 1'b1;
        ptr       <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_module_display_arbiter.sv
module tb_module_display_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned HC = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic [W-1:0]   disp_data;
  logic           disp_we;
  logic           busy;
  logic [W-1:0]   words [N];

  typedef struct packed {
    logic [W-1:0] data;
    logic [N-1:0] ack;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always_comb req_data = {words[3], words[2], words[1], words[0]};

  module_display_arbiter #(
    .N_REQ       (N),
    .DATA_W      (W),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .grant     (grant),
    .disp_data (disp_data),
    .disp_we   (disp_we),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) words[i] = '0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int we_seen;
    do_reset();
    tests++;
    if (disp_we !== 1'b0 || busy !== 1'b0 || grant !== '0 || ack !== '0 || disp_data !== '0) begin
      fails++;
      $display("FAIL reset_values: we=%b busy=%b grant=%b ack=%b data=%h, required 0 0 0000 0000 0000",
               disp_we, busy, grant, ack, disp_data);
    end
    we_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (disp_we !== 1'b0 || busy !== 1'b0) we_seen++;
    end
    tests++;
    if (we_seen != 0 || disp_data !== 16'h0000) begin
      fails++;
      $display("FAIL idle_no_req: active cycles=%0d data=%h, required 0 and 0000", we_seen, disp_data);
    end
  endtask

  task automatic test_single();
    int req_cyc, busy_cnt, lat;
    exp_t e;
    words[2] = 16'hBEEF;
    req      = 4'b0100;
    req_cyc  = cyc;
    exp_q.push_back('{data: 16'hBEEF, ack: 4'b0100});
    busy_cnt = 0;
    lat      = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (disp_we === 1'b1) begin
        lat = cyc - req_cyc;
        req = '0;
        e   = exp_q.pop_front();
        tests++;
        if (disp_data !== e.data || ack !== e.ack || grant !== 4'b0100) begin
          fails++;
          $display("FAIL single_write: data=%h ack=%b grant=%b, required %h %b 0100",
                   disp_data, ack, grant, e.data, e.ack);
        end
      end
    end
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL single_latency: edges to we=%0d, required 1", lat);
    end
    tests++;
    if (busy_cnt != int'(HC) + 1) begin
      fails++;
      $display("FAIL single_busy: busy cycles=%0d, required %0d", busy_cnt, HC + 1);
    end
  endtask

  task automatic test_back_to_back();
    int last_cyc, n;
    exp_t e;
    do_reset();
    for (int i = 0; i < N; i++) words[i] = W'(i);
    for (int i = 0; i < 5; i++) exp_q.push_back('{data: W'(i % 4), ack: N'(1 << (i % 4))});
    req      = 4'b1111;
    last_cyc = -1;
    n        = 0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (disp_we === 1'b1) begin
        e = exp_q.pop_front();
        n++;
        if (n == 5) req = '0;
        tests++;
        if (disp_data !== e.data || ack !== e.ack) begin
          fails++;
          $display("FAIL rr_write%0d: data=%h ack=%b, required %h %b", n, disp_data, ack, e.data, e.ack);
        end
        if (last_cyc >= 0) begin
          tests++;
          if (cyc - last_cyc != int'(HC) + 1) begin
            fails++;
            $display("FAIL rr_spacing%0d: spacing=%0d, required %0d", n, cyc - last_cyc, HC + 1);
          end
        end
        last_cyc = cyc;
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rr_timeout: %0d writes missing, required 0", exp_q.size());
    end
    for (int c = 0; c < 10; c++) @(negedge clk);
  endtask

  task automatic test_capture_hold();
    int bad;
    exp_t e;
    do_reset();
    words[0] = 16'h1234;
    req      = 4'b0001;
    exp_q.push_back('{data: 16'h1234, ack: 4'b0001});
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (disp_we === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if (disp_data !== e.data || ack !== e.ack) begin
          fails++;
          $display("FAIL cap_write: data=%h ack=%b, required %h %b", disp_data, ack, e.data, e.ack);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL cap_timeout: %0d writes missing, required 0", exp_q.size());
    end
    @(negedge clk);
    words[0] = 16'h5678;
    req      = '0;
    bad      = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (disp_we !== 1'b0 || disp_data !== 16'h1234) bad++;
    end
    tests++;
    if (bad != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL cap_stable: bad cycles=%0d busy=%b data=%h, required 0 0 1234", bad, busy, disp_data);
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e;
    do_reset();
    words[0] = 16'hAAAA;
    req      = 4'b0001;
    for (int c = 0; c < 10 && disp_we !== 1'b1; c++) @(negedge clk);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (disp_we !== 1'b0 || busy !== 1'b0 || grant !== '0 || ack !== '0 || disp_data !== '0) begin
      fails++;
      $display("FAIL async_reset: we=%b busy=%b grant=%b ack=%b data=%h, required all 0",
               disp_we, busy, grant, ack, disp_data);
    end
    @(negedge clk);
    rst      = 1'b1;
    words[1] = 16'h1111;
    words[2] = 16'h2222;
    req      = 4'b0111;
    exp_q.push_back('{data: 16'hAAAA, ack: 4'b0001});
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (disp_we === 1'b1) begin
        req = '0;
        e   = exp_q.pop_front();
        tests++;
        if (disp_data !== e.data || ack !== e.ack) begin
          fails++;
          $display("FAIL post_reset_winner: data=%h ack=%b, required %h %b", disp_data, ack, e.data, e.ack);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL post_reset_timeout: %0d writes missing, required 0", exp_q.size());
    end
    for (int c = 0; c < 10; c++) @(negedge clk);
  endtask

  task automatic test_rr_pointer();
    logic [N-1:0] next_req [3];
    int n;
    exp_t e;
    do_reset();
    words[0] = 16'h0A0A;
    words[2] = 16'h2C2C;
    next_req[0] = 4'b0101;
    next_req[1] = 4'b0100;
    next_req[2] = 4'b0000;
    exp_q.push_back('{data: 16'h2C2C, ack: 4'b0100});
    exp_q.push_back('{data: 16'h0A0A, ack: 4'b0001});
    exp_q.push_back('{data: 16'h2C2C, ack: 4'b0100});
    req = 4'b0100;
    n   = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (disp_we === 1'b1) begin
        e   = exp_q.pop_front();
        req = next_req[n];
        n++;
        tests++;
        if (disp_data !== e.data || ack !== e.ack) begin
          fails++;
          $display("FAIL ptr_write%0d: data=%h ack=%b, required %h %b", n, disp_data, ack, e.data, e.ack);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL ptr_timeout: %0d writes missing, required 0", exp_q.size());
    end
    for (int c = 0; c < 10; c++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) words[i] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_capture_hold();
    test_reset_mid_hold();
    test_rr_pointer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
